// File: rtl/esaxi_ram.sv
// esaxi_ram: AXI3 slave responder with a simple dual-port 64-bit RAM, terminating the emaxi master port.
// Optional macro ESAXI_RAM_ERRRESP_EN decodes bursts starting outside the RAM window as SLVERR.
module esaxi_ram #(
    parameter int          M_IDW = 6,
    parameter int          MAW   = 10,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic [M_IDW-1:0] m_axi_awid,
    input  logic [31:0]      m_axi_awaddr,
    input  logic [7:0]       m_axi_awlen,
    input  logic [2:0]       m_axi_awsize,
    input  logic [1:0]       m_axi_awburst,
    input  logic             m_axi_awvalid,
    output logic             m_axi_awready,
    input  logic [M_IDW-1:0] m_axi_wid,
    input  logic [63:0]      m_axi_wdata,
    input  logic [7:0]       m_axi_wstrb,
    input  logic             m_axi_wlast,
    input  logic             m_axi_wvalid,
    output logic             m_axi_wready,
    output logic [M_IDW-1:0] m_axi_bid,
    output logic [1:0]       m_axi_bresp,
    output logic             m_axi_bvalid,
    input  logic             m_axi_bready,
    input  logic [M_IDW-1:0] m_axi_arid,
    input  logic [31:0]      m_axi_araddr,
    input  logic [7:0]       m_axi_arlen,
    input  logic [2:0]       m_axi_arsize,
    input  logic [1:0]       m_axi_arburst,
    input  logic             m_axi_arvalid,
    output logic             m_axi_arready,
    output logic [M_IDW-1:0] m_axi_rid,
    output logic [63:0]      m_axi_rdata,
    output logic [1:0]       m_axi_rresp,
    output logic             m_axi_rlast,
    output logic             m_axi_rvalid,
    input  logic             m_axi_rready
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rState_t;

    logic [63:0]      r_mem [0:(1<<MAW)-1];
    wState_t          r_wState, w_wNext;
    logic [M_IDW-1:0] r_wId;
    logic [MAW-1:0]   r_wAddr;
    logic [7:0]       r_wLen, r_wCnt;
    logic             r_wFixed, r_wErr;
    rState_t          r_rState, w_rNext;
    logic [M_IDW-1:0] r_rId;
    logic [MAW-1:0]   r_rAddr;
    logic [7:0]       r_rLen, r_rCnt;
    logic             r_rFixed, r_rErr;
    logic [63:0]      r_ramQ;
    logic             w_awHs, w_wBeat, w_arHs, w_rHs, w_awErr, w_arErr, w_rdEn;
    logic [MAW-1:0]   w_rNextAddr, w_rdAddr;
    logic             w_unused;

`ifdef ESAXI_RAM_ERRRESP_EN
    localparam logic [32:0] WIN_BYTES = 33'd8 << MAW;
    // Offsets below BASE go negative and therefore also compare as out of window.
    assign w_awErr = (({1'b0, m_axi_awaddr} - {1'b0, BASE}) >= WIN_BYTES);
    assign w_arErr = (({1'b0, m_axi_araddr} - {1'b0, BASE}) >= WIN_BYTES);
`else
    assign w_awErr = 1'b0;
    assign w_arErr = 1'b0;
`endif

    assign w_unused = ^{m_axi_awaddr[2:0], m_axi_awaddr[31:MAW+3], m_axi_araddr[2:0],
                        m_axi_araddr[31:MAW+3], m_axi_awsize, m_axi_arsize, m_axi_wid,
                        m_axi_wlast, BASE};

    assign w_awHs = m_axi_awvalid && m_axi_awready;
    assign w_wBeat = m_axi_wvalid && m_axi_wready;
    assign w_arHs = m_axi_arvalid && m_axi_arready;
    assign w_rHs = m_axi_rvalid && m_axi_rready;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_wState <= W_IDLE;
            r_rState <= R_IDLE;
        end else begin
            r_wState <= w_wNext;
            r_rState <= w_rNext;
        end
    end

    always_comb begin
        w_wNext = r_wState;
        m_axi_awready = 1'b0;
        m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0;
        if (!reset) begin
            case (r_wState)
                W_IDLE: begin
                    m_axi_awready = 1'b1;
                    if (m_axi_awvalid) w_wNext = W_DATA;
                end
                W_DATA: begin
                    m_axi_wready = 1'b1;
                    if (m_axi_wvalid && (r_wCnt == r_wLen)) w_wNext = W_RESP;
                end
                W_RESP: begin
                    m_axi_bvalid = 1'b1;
                    if (m_axi_bready) w_wNext = W_IDLE;
                end
                default: w_wNext = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_wId <= '0;
            r_wAddr <= '0;
            r_wLen <= '0;
            r_wCnt <= '0;
            r_wFixed <= 1'b0;
            r_wErr <= 1'b0;
        end else if (w_awHs) begin
            r_wId <= m_axi_awid;
            r_wAddr <= m_axi_awaddr[MAW+2:3];
            r_wLen <= m_axi_awlen;
            r_wCnt <= '0;
            r_wFixed <= (m_axi_awburst == 2'b00);
            r_wErr <= w_awErr;
        end else if (w_wBeat) begin
            r_wCnt <= r_wCnt + 8'd1;
            if (!r_wFixed) r_wAddr <= r_wAddr + MAW'(1);
        end
    end

    // RAM contents survive reset; error bursts are accepted but never stored.
    always_ff @(posedge sys_clk) begin
        if (w_wBeat && !r_wErr) begin
            for (int b = 0; b < 8; b++) begin
                if (m_axi_wstrb[b]) r_mem[r_wAddr][b*8 +: 8] <= m_axi_wdata[b*8 +: 8];
            end
        end
    end

    assign m_axi_bid = r_wId;
    assign m_axi_bresp = r_wErr ? 2'b10 : 2'b00;

    always_comb begin
        w_rNext = r_rState;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        if (!reset) begin
            case (r_rState)
                R_IDLE: begin
                    m_axi_arready = 1'b1;
                    if (m_axi_arvalid) w_rNext = R_FETCH;
                end
                R_FETCH: w_rNext = R_DATA;
                R_DATA: begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rlast = (r_rCnt == r_rLen);
                    if (m_axi_rready && (r_rCnt == r_rLen)) w_rNext = R_IDLE;
                end
                default: w_rNext = R_IDLE;
            endcase
        end
    end

    // The RAM is only read on fetch or on an accepted beat, so stalled rdata cannot change.
    assign w_rNextAddr = r_rFixed ? r_rAddr : r_rAddr + MAW'(1);
    assign w_rdEn = (r_rState == R_FETCH) || (w_rHs && (r_rCnt != r_rLen));
    assign w_rdAddr = (r_rState == R_FETCH) ? r_rAddr : w_rNextAddr;

    always_ff @(posedge sys_clk) begin
        if (w_rdEn) r_ramQ <= r_mem[w_rdAddr];
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_rId <= '0;
            r_rAddr <= '0;
            r_rLen <= '0;
            r_rCnt <= '0;
            r_rFixed <= 1'b0;
            r_rErr <= 1'b0;
        end else if (w_arHs) begin
            r_rId <= m_axi_arid;
            r_rAddr <= m_axi_araddr[MAW+2:3];
            r_rLen <= m_axi_arlen;
            r_rCnt <= '0;
            r_rFixed <= (m_axi_arburst == 2'b00);
            r_rErr <= w_arErr;
        end else if (w_rHs) begin
            r_rCnt <= r_rCnt + 8'd1;
            r_rAddr <= w_rNextAddr;
        end
    end

    assign m_axi_rid = r_rId;
    assign m_axi_rdata = r_rErr ? 64'h0 : r_ramQ;
    assign m_axi_rresp = r_rErr ? 2'b10 : 2'b00;

endmodule
